ram_rd_stream: RTL and testbench

- Read-side master that sits directly upstream of the handshake RAM wrapper.
- Accepts a burst command (base address, word count) and issues one read per cycle on the wrapper's arvalid/araddr channel.
- Collects returned words through rvalid/rready into a small output FIFO and presents them as a valid/ready stream with a last flag.
- Feeds compute stages that need linear SRAM sweeps with backpressure.

---
 rtl/ram_rd_stream_pkg.sv | 17 +
 rtl/rd_stream_fifo.sv | 65 ++++++
 rtl/ram_rd_stream.sv | 161 ++++++++++++++++
 tb/tb_ram_rd_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_stream_pkg.sv
// rtl/ram_rd_stream_pkg.sv - shared state encoding and FIFO entry layout for ram_rd_stream
package ram_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // A FIFO entry is {last, data}: the last tag sits just above the data word.
    localparam int unsigned ENTRY_LAST_W = 1;

    function automatic int unsigned entry_width(input int unsigned data_w);
        return data_w + ENTRY_LAST_W;
    endfunction

endpackage

// File: rtl/rd_stream_fifo.sv
// rtl/rd_stream_fifo.sv - synchronous power-of-two FIFO holding returned read words
module rd_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 129
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ram_rd_stream.sv
// rtl/ram_rd_stream.sv - burst read master feeding a valid/ready stream from the RAM wrapper
// Optional stall counter output perf_stall_cnt is built when RD_STREAM_PERF_EN is defined.
module ram_rd_stream
    import ram_rd_stream_pkg::*;
#(
    parameter int SRAM_WIDTH     = 128,
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int LEN_BIT        = 7,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SRAM_DEPTH_BIT-1:0] cmd_addr,
    input  logic [LEN_BIT-1:0]        cmd_len,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [SRAM_DEPTH_BIT-1:0] araddr,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [SRAM_WIDTH-1:0]     rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SRAM_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      busy
`ifdef RD_STREAM_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt
`endif
);
    localparam int ENTRY_W = entry_width(SRAM_WIDTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    state_e                    state_q, state_d;
    logic [SRAM_DEPTH_BIT-1:0] base_q, base_d;
    logic [LEN_BIT-1:0]        len_q, len_d;
    logic [LEN_BIT-1:0]        issue_q, issue_d;
    logic [LEN_BIT-1:0]        recv_q, recv_d;
    logic                      rready_q, rready_d;

    logic                      push;
    logic                      pop;
    logic [ENTRY_W-1:0]        push_entry;
    logic [ENTRY_W-1:0]        head_entry;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W-1:0]          next_count;
    logic                      fifo_empty;
    logic                      fifo_full;

    rd_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rready    = rready_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : head_entry[SRAM_WIDTH-1:0];
    assign out_last  = !fifo_empty && head_entry[SRAM_WIDTH];
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issue_d    = issue_q;
        recv_d     = recv_q;
        cmd_ready  = (state_q == ST_IDLE);
        arvalid    = (state_q == ST_RD) && rready_q;
        araddr     = base_q + SRAM_DEPTH_BIT'(issue_q);
        push       = rvalid && rready_q && (recv_q != len_q) && !fifo_full;
        push_entry = {(recv_q == len_q - LEN_BIT'(1)), rdata};
        pop        = out_ready && !fifo_empty;
        if (push) begin
            recv_d = recv_q + LEN_BIT'(1);
        end
        // rready is registered from the post-edge occupancy so a word issued
        // this cycle always finds a free slot when it returns next cycle.
        next_count = fifo_count + CNT_W'(push) - CNT_W'(pop);
        rready_d   = (next_count <= CNT_W'(FIFO_DEPTH - 2));

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_len != '0) begin
                    base_d  = cmd_addr;
                    len_d   = cmd_len;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (arvalid && arready) begin
                    issue_d = issue_q + LEN_BIT'(1);
                    if (issue_q + LEN_BIT'(1) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (recv_q == len_q && fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issue_q  <= '0;
            recv_q   <= '0;
            rready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issue_q  <= issue_d;
            recv_q   <= recv_d;
            rready_q <= rready_d;
        end
    end

`ifdef RD_STREAM_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (cmd_valid && state_q == ST_IDLE) begin
            perf_d = '0;
        end else if (!fifo_empty && !out_ready) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// tb/tb_ram_rd_stream.sv - table-driven bench for ram_rd_stream with a handshake RAM model
module tb_ram_rd_stream;
    localparam int SW = 128;
    localparam int AW = 6;
    localparam int LW = 7;
    localparam int FD = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid;
    logic          rready;
    logic [SW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef RD_STREAM_PERF_EN
    logic [31:0]   perf_stall_cnt;
`endif

    ram_rd_stream #(
        .SRAM_WIDTH     (SW),
        .SRAM_DEPTH_BIT (AW),
        .LEN_BIT        (LW),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef RD_STREAM_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] mem_word(input logic [AW-1:0] a);
        return {32'hC0DE_0000 | 32'(a), ~{26'h0, a}, 32'(a) * 32'd3, {26'h0, a}};
    endfunction

    // RAM wrapper model: one-cycle read latency, word held while rready is low.
    logic          rv;
    logic [SW-1:0] rd;
    assign arready = rready;
    assign rvalid  = rv;
    assign rdata   = rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv <= 1'b0;
            rd <= '0;
        end else begin
            if (rv && rready) rv <= 1'b0;
            if (arvalid && arready) begin
                rv <= 1'b1;
                rd <= mem_word(araddr);
            end
        end
    end

    logic [SW-1:0] got_data[$];
    logic          got_last[$];
    logic [AW-1:0] got_addr[$];
    int            idle_viol;
    bit            watch_idle;
    int            n_vec;
    int            n_bad;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (rst_n && arvalid && arready) got_addr.push_back(araddr);
        if (watch_idle && (arvalid || out_valid)) idle_viol++;
    end

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        got_data.delete();
        got_last.delete();
        got_addr.delete();
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            stall_start;
        int            stall_len;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int            cyc;
        int            lat;
        logic [AW-1:0] ea;
        clear_q();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        out_ready = 1'b1;
        @(negedge clk);
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1;
        while (got_data.size() < int'(v.len) && cyc < 600) begin
            out_ready = !(v.stall_len != 0 && cyc >= v.stall_start && cyc < v.stall_start + v.stall_len);
            @(negedge clk);
            if (v.stall_len >= 10 && cyc == v.stall_start + 8) check("rready_backpressure", rready, 1'b0);
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (busy && lat < 20);
        check("busy_fall_latency", lat, 2);
        check("word_count", got_data.size(), v.len);
        check("issue_count", got_addr.size(), v.len);
        if (got_addr.size() == int'(v.len)) begin
            check("first_addr", got_addr[0], v.exp_first);
            check("last_addr", got_addr[v.len - 1], v.exp_last);
        end
        for (int k = 0; k < got_data.size() && k < int'(v.len); k++) begin
            ea = v.exp_first + AW'(k);
            check("data", got_data[k], mem_word(ea));
            check("last", got_last[k], (k == int'(v.len) - 1));
            if (k < got_addr.size()) check("araddr", got_addr[k], ea);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_araddr", araddr, '0);
        check("rst_rready", rready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
    endtask

    initial begin
        int cnt;
        n_vec      = 0;
        n_bad      = 0;
        idle_viol  = 0;
        watch_idle = 1'b0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        out_ready  = 1'b1;

        vecs[0] = '{6'd5,  7'd4,   0,  0,  6'd5,  6'd8};
        vecs[1] = '{6'd0,  7'd8,   4,  10, 6'd0,  6'd7};
        vecs[2] = '{6'd62, 7'd4,   0,  0,  6'd62, 6'd1};
        vecs[3] = '{6'd10, 7'd1,   0,  0,  6'd10, 6'd10};
        vecs[4] = '{6'd33, 7'd127, 50, 3,  6'd33, 6'd31};
        vecs[5] = '{6'd63, 7'd2,   2,  5,  6'd63, 6'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Empty burst: accepted at once, nothing issued or streamed.
        clear_q();
        idle_viol  = 0;
        watch_idle = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 6'd7;
        cmd_len   = '0;
        @(negedge clk);
        check("empty_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("empty_no_activity", idle_viol, 0);
        check("empty_no_issue", got_addr.size(), 0);
        check("empty_busy", busy, 1'b0);
        check("empty_cmd_ready", cmd_ready, 1'b1);
        watch_idle = 1'b0;

        // Reset after 3 of 8 words, then a fresh short burst.
        clear_q();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 6'd0;
        cmd_len   = 7'd8;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cnt = 0;
        while (got_data.size() < 3 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("pre_reset_words", got_data.size(), 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec('{6'd10, 7'd2, 0, 0, 6'd10, 6'd11});

`ifdef RD_STREAM_PERF_EN
        clear_q();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 6'd20;
        cmd_len   = 7'd4;
        out_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("perf_start", perf_stall_cnt, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("perf_stall_cnt", perf_stall_cnt, 32'd5);
        cnt = 0;
        while (busy && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("perf_words", got_data.size(), 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
